epc_ctrl: RTL and testbench

//  Exception/return sequencer that drives the PC adder's get02, getEpc and epcValue.
//  On an illegal instruction (SIIC) it saves the return PC into the EPC and redirects

---
 rtl/epc_ctrl.sv | 128 ++++++++++++
 tb/tb_epc_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/epc_ctrl.sv
// epc_ctrl: exception/return sequencer feeding get02/getEpc/epcValue to the PC adder.
// Build option: define NESTED_EXC_EN to turn the single EPC into a NEST_DEPTH-entry LIFO.
module epc_ctrl #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] EPC_RESET  = 16'h0000,
  parameter int               NEST_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic             stall,
  input  logic             siic,
  input  logic             rti,
  input  logic [WIDTH-1:0] pc_plus2,
  output logic [WIDTH-1:0] epcValue,
  output logic             get02,
  output logic             getEpc,
  output logic             flush,
  output logic             in_handler,
  output logic             err
);

`ifdef NESTED_EXC_EN
  localparam int DEPTH = NEST_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(NEST_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_VEC     = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;
  localparam logic [1:0] S_RET     = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] w_below;
  logic             r_get02, r_getepc, r_flush, r_in_handler, r_err;
  logic             w_take, w_full, w_last, w_push, w_pop, w_err_next;

  assign w_take = inst_valid & ~stall;
  assign w_full = (int'(r_cnt) >= DEPTH);
  assign w_last = (int'(r_cnt) == 1);

  // Entry that becomes top of stack after a pop; with one or no entries left the
  // visible EPC simply keeps the value just returned to.
  always_comb begin
    w_below = r_epc;
    for (int k = 0; k < DEPTH; k++) begin
      if (k + 2 == int'(r_cnt)) w_below = r_stack[k];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take && siic) begin
          w_state_next = S_VEC;
          w_push       = 1'b1;
          w_err_next   = rti;
        end else if (w_take && rti) begin
          w_err_next = 1'b1;
        end
      end
      S_VEC: w_state_next = S_HANDLER;
      S_HANDLER: begin
        // A full stack still vectors, but keeps the existing return address.
        if (w_take && siic) begin
          w_state_next = S_VEC;
          w_push       = ~w_full;
          w_err_next   = rti | w_full;
        end else if (w_take && rti) begin
          w_state_next = S_RET;
        end
      end
      default: begin
        w_pop        = 1'b1;
        w_state_next = w_last ? S_IDLE : S_HANDLER;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_epc        <= EPC_RESET;
      r_get02      <= 1'b0;
      r_getepc     <= 1'b0;
      r_flush      <= 1'b0;
      r_in_handler <= 1'b0;
      r_err        <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_stack[k] <= EPC_RESET;
    end else begin
      r_state      <= w_state_next;
      r_get02      <= (w_state_next == S_VEC);
      r_getepc     <= (w_state_next == S_RET);
      r_flush      <= (w_state_next == S_VEC) || (w_state_next == S_RET);
      r_in_handler <= (w_state_next != S_IDLE);
      r_err        <= w_err_next;
      if (w_push) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == int'(r_cnt)) r_stack[k] <= pc_plus2;
        end
        r_cnt <= r_cnt + CW'(1);
        r_epc <= pc_plus2;
      end else if (w_pop) begin
        r_cnt <= r_cnt - CW'(1);
        r_epc <= w_below;
      end
    end
  end

  assign epcValue   = r_epc;
  assign get02      = r_get02;
  assign getEpc     = r_getepc;
  assign flush      = r_flush;
  assign in_handler = r_in_handler;
  assign err        = r_err;

endmodule

// File: tb/tb_epc_ctrl.sv
// tb_epc_ctrl: scoreboard bench for epc_ctrl; a queue-based reference model predicts
// each cycle's registered outputs, and a monitor compares them after every clock edge.
module tb_epc_ctrl;
`ifdef NESTED_EXC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        stall = 1'b0;
  logic        siic = 1'b0;
  logic        rti = 1'b0;
  logic [15:0] pc_plus2 = 16'h0000;
  logic [15:0] epcValue;
  logic        get02, getEpc, flush, in_handler, err;

  epc_ctrl #(.WIDTH(16), .EPC_RESET(16'h0000), .NEST_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .stall(stall),
    .siic(siic), .rti(rti), .pc_plus2(pc_plus2), .epcValue(epcValue),
    .get02(get02), .getEpc(getEpc), .flush(flush), .in_handler(in_handler), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        get02;
    logic        getepc;
    logic        flush;
    logic        in_h;
    logic        err;
    logic [15:0] epc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: saved return addresses, last returned address, and whether the
  // cycle now in progress is a vector or return redirect (inputs ignored then).
  logic [15:0] m_stk[$];
  logic [15:0] m_last = 16'h0000;
  bit          m_vec_now = 1'b0;
  bit          m_ret_now = 1'b0;

  task automatic model_reset();
    m_stk.delete();
    m_last    = 16'h0000;
    m_vec_now = 1'b0;
    m_ret_now = 1'b0;
  endtask

  task automatic model_step(input bit iv, input bit st, input bit si, input bit rt,
                            input logic [15:0] pc);
    exp_t e;
    bit take;
    bit vec;
    bit ret;
    bit er;
    take = iv & ~st;
    vec  = 1'b0;
    ret  = 1'b0;
    er   = 1'b0;
    if (m_ret_now) begin
      m_last = m_stk.pop_back();
    end else if (!m_vec_now && take && si) begin
      vec = 1'b1;
      er  = rt;
      if (m_stk.size() < DEPTH) m_stk.push_back(pc);
      else er = 1'b1;
    end else if (!m_vec_now && take && rt) begin
      if (m_stk.size() == 0) er = 1'b1;
      else ret = 1'b1;
    end
    m_vec_now = vec;
    m_ret_now = ret;
    e.get02  = vec;
    e.getepc = ret;
    e.flush  = vec | ret;
    e.err    = er;
    e.in_h   = (m_stk.size() != 0);
    e.epc    = (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : m_last;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit iv, input bit st, input bit si, input bit rt,
                       input logic [15:0] pc);
    @(negedge clk);
    inst_valid = iv;
    stall      = st;
    siic       = si;
    rti        = rt;
    pc_plus2   = pc;
    model_step(iv, st, si, rt, pc);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({get02, getEpc, flush, in_handler, err} !== 5'b0 || epcValue !== 16'h0000) begin
      errors++;
      $display("FAIL %s: got get02=%b getEpc=%b flush=%b in_handler=%b err=%b epc=%h, required all 0 epc=0000",
               name, get02, getEpc, flush, in_handler, err, epcValue);
    end else begin
      $display("check %s: outputs cleared", name);
    end
  endtask

  // Monitor: every edge, pop the predicted outputs and compare.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {get02, getEpc, flush, in_handler, err, epcValue};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_out @%0t: got get02=%b getEpc=%b flush=%b in_handler=%b err=%b epc=%h, required get02=%b getEpc=%b flush=%b in_handler=%b err=%b epc=%h",
                   $time, a.get02, a.getepc, a.flush, a.in_h, a.err, a.epc,
                   e.get02, e.getepc, e.flush, e.in_h, e.err, e.epc);
        end else begin
          $display("txn @%0t: get02=%b getEpc=%b flush=%b in_handler=%b err=%b epc=%h",
                   $time, a.get02, a.getepc, a.flush, a.in_h, a.err, a.epc);
        end
      end
    end
  end

  initial begin
    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_valid = 1'($urandom);
      stall      = 1'($urandom);
      siic       = 1'($urandom);
      rti        = 1'($urandom);
      pc_plus2   = 16'($urandom);
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end
    @(negedge clk);
    inst_valid = 1'b0; stall = 1'b0; siic = 1'b0; rti = 1'b0; pc_plus2 = 16'h0000;
    rst_n = 1'b1;
    model_reset();

    // Basic exception and return.
    drive(1, 0, 1, 0, 16'h1234);
    drive_idle(2);
    drive(1, 0, 0, 1, 16'h0000);
    drive_idle(2);
    // RTI with nothing outstanding, stalled and invalid SIIC.
    drive(1, 0, 0, 1, 16'h0000);
    drive(1, 1, 1, 0, 16'h5555);
    drive(0, 0, 1, 0, 16'h6666);
    drive_idle(1);
    // Nested exception; the cycle after the first SIIC carries an ignored SIIC.
    drive(1, 0, 1, 0, 16'h1234);
    drive(1, 0, 1, 1, 16'h7777);
    drive(1, 0, 1, 0, 16'h0040);
    drive_idle(1);
    drive(1, 0, 0, 1, 16'h0000);
    drive(1, 0, 0, 1, 16'h0000);
    drive_idle(1);
    drive(1, 0, 0, 1, 16'h0000);
    drive_idle(2);
    // Simultaneous SIIC and RTI from idle, then return.
    drive(1, 0, 1, 1, 16'hFFFF);
    drive_idle(1);
    drive(1, 0, 0, 1, 16'h0000);
    drive_idle(2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
            ($urandom % 4) == 0, 16'($urandom));
    end
    drive_idle(1);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 16'h0000);
    drive_idle(2);

    // Reset asserted during the vector cycle.
    drive(1, 0, 1, 0, 16'h2222);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_vec");
    model_reset();
    @(negedge clk);
    inst_valid = 1'b0; stall = 1'b0; siic = 1'b0; rti = 1'b0; pc_plus2 = 16'h0000;
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 16'h0000);
    drive(1, 0, 1, 0, 16'h3344);
    drive_idle(1);
    drive(1, 0, 0, 1, 16'h0000);
    drive_idle(2);

    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
